// File: rtl/cpu_run_dump_ctrl.sv
// Run controller for the multicycle CPU: gates cpu_run for a cycle budget or
// until halt, then reads back the first DUMP_DEPTH data-memory words over valid/ready.
module cpu_run_dump_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int DUMP_DEPTH = 16,
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 45,
  parameter int MEM_RD_LAT = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [CYCLE_W-1:0] cycle_limit,
  input  logic               cpu_halt,
  output logic               cpu_run,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0]  mem_rd_data,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [ADDR_W-1:0]  dump_addr,
  output logic [DATA_W-1:0]  dump_data,
  output logic               dump_last,
  output logic               busy,
  output logic               done,
  output logic [CYCLE_W-1:0] cycles_run,
  output logic [1:0]         stop_cause
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_OUT     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int                  WAIT_W    = 3;
  localparam logic [WAIT_W-1:0]   WAIT_END  = WAIT_W'(MEM_RD_LAT - 1);
  localparam logic [WAIT_W-1:0]   WAIT_ONE  = WAIT_W'(1);
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DUMP_DEPTH - 1);
  localparam logic [ADDR_W-1:0]   ADDR_ONE  = ADDR_W'(1);
  localparam logic [CYCLE_W-1:0]  DEF_LIMIT = CYCLE_W'(MAX_CYCLES);
  localparam logic [CYCLE_W-1:0]  CYC_ONE   = CYCLE_W'(1);

  state_t              state_r, state_s;
  logic [CYCLE_W-1:0]  limit_r, limit_s;
  logic [ADDR_W-1:0]   ptr_r, ptr_s;
  logic [WAIT_W-1:0]   wait_r, wait_s;
  logic                cpu_run_r, cpu_run_s;
  logic                mem_rd_en_r, mem_rd_en_s;
  logic                dump_valid_r, dump_valid_s;
  logic [ADDR_W-1:0]   dump_addr_r, dump_addr_s;
  logic [DATA_W-1:0]   dump_data_r, dump_data_s;
  logic                dump_last_r, dump_last_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic [CYCLE_W-1:0]  cycles_run_r, cycles_run_s;
  logic [1:0]          stop_cause_r, stop_cause_s;
  logic                hit_lim_s, hit_halt_s;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s      = state_r;
    limit_s      = limit_r;
    ptr_s        = ptr_r;
    wait_s       = wait_r;
    cpu_run_s    = 1'b0;
    mem_rd_en_s  = 1'b0;
    dump_valid_s = dump_valid_r;
    dump_addr_s  = dump_addr_r;
    dump_data_s  = dump_data_r;
    dump_last_s  = dump_last_r;
    cycles_run_s = cycles_run_r;
    stop_cause_s = stop_cause_r;
    hit_lim_s    = 1'b0;
    hit_halt_s   = 1'b0;

    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s      = S_RUN;
          limit_s      = (cycle_limit == {CYCLE_W{1'b0}}) ? DEF_LIMIT : cycle_limit;
          cycles_run_s = {CYCLE_W{1'b0}};
          stop_cause_s = 2'b00;
          ptr_s        = {ADDR_W{1'b0}};
          cpu_run_s    = 1'b1;
        end else begin
          state_s = state_r;
        end
      end

      S_RUN: begin
        // The count ends at the limit itself, so it can never overrun its width.
        cycles_run_s = cycles_run_r + CYC_ONE;
        hit_lim_s    = ((cycles_run_r + CYC_ONE) == limit_r);
        hit_halt_s   = cpu_halt;
        if (hit_lim_s || hit_halt_s) begin
          stop_cause_s = {hit_halt_s, hit_lim_s};
          state_s      = S_RD_REQ;
          mem_rd_en_s  = 1'b1;
        end else begin
          cpu_run_s = 1'b1;
        end
      end

      S_RD_REQ: begin
        state_s = S_RD_WAIT;
        wait_s  = {WAIT_W{1'b0}};
      end

      S_RD_WAIT: begin
        if (wait_r == WAIT_END) begin
          state_s      = S_OUT;
          dump_data_s  = mem_rd_data;
          dump_addr_s  = ptr_r;
          dump_last_s  = (ptr_r == LAST_ADDR);
          dump_valid_s = 1'b1;
        end else begin
          wait_s = wait_r + WAIT_ONE;
        end
      end

      S_OUT: begin
        // Only the final word skips the increment, so the pointer never wraps.
        if (dump_ready) begin
          dump_valid_s = 1'b0;
          if (dump_last_r) begin
            state_s = S_DONE;
          end else begin
            ptr_s       = ptr_r + ADDR_ONE;
            state_s     = S_RD_REQ;
            mem_rd_en_s = 1'b1;
          end
        end else begin
          state_s = S_OUT;
        end
      end

      default: begin
        state_s      = S_IDLE;
        dump_valid_s = 1'b0;
      end
    endcase

    busy_s = (state_s != S_IDLE) && (state_s != S_DONE);
    done_s = (state_s == S_DONE);
  end

  // State and output registers; async reset aborts any run or dump at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      limit_r      <= {CYCLE_W{1'b0}};
      ptr_r        <= {ADDR_W{1'b0}};
      wait_r       <= {WAIT_W{1'b0}};
      cpu_run_r    <= 1'b0;
      mem_rd_en_r  <= 1'b0;
      dump_valid_r <= 1'b0;
      dump_addr_r  <= {ADDR_W{1'b0}};
      dump_data_r  <= {DATA_W{1'b0}};
      dump_last_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cycles_run_r <= {CYCLE_W{1'b0}};
      stop_cause_r <= 2'b00;
    end else begin
      state_r      <= state_s;
      limit_r      <= limit_s;
      ptr_r        <= ptr_s;
      wait_r       <= wait_s;
      cpu_run_r    <= cpu_run_s;
      mem_rd_en_r  <= mem_rd_en_s;
      dump_valid_r <= dump_valid_s;
      dump_addr_r  <= dump_addr_s;
      dump_data_r  <= dump_data_s;
      dump_last_r  <= dump_last_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      cycles_run_r <= cycles_run_s;
      stop_cause_r <= stop_cause_s;
    end
  end

  assign cpu_run     = cpu_run_r;
  assign mem_rd_en   = mem_rd_en_r;
  assign mem_rd_addr = ptr_r;
  assign dump_valid  = dump_valid_r;
  assign dump_addr   = dump_addr_r;
  assign dump_data   = dump_data_r;
  assign dump_last   = dump_last_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign cycles_run  = cycles_run_r;
  assign stop_cause  = stop_cause_r;

endmodule

// File: tb/tb_cpu_run_dump_ctrl.sv
// Bench for cpu_run_dump_ctrl: instance a (default parameters) and instance b
// (read latency 3, depth 4), each with a behavioural data memory.
module tb_cpu_run_dump_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic          a_start, a_cpu_halt, a_cpu_run, a_mem_rd_en, a_dump_valid, a_dump_ready;
  logic          a_dump_last, a_busy, a_done;
  logic [CW-1:0] a_cycle_limit, a_cycles_run;
  logic [AW-1:0] a_mem_rd_addr, a_dump_addr;
  logic [DW-1:0] a_mem_rd_data, a_dump_data;
  logic [1:0]    a_stop_cause;

  logic          b_start, b_cpu_halt, b_cpu_run, b_mem_rd_en, b_dump_valid, b_dump_ready;
  logic          b_dump_last, b_busy, b_done;
  logic [CW-1:0] b_cycle_limit, b_cycles_run;
  logic [AW-1:0] b_mem_rd_addr, b_dump_addr;
  logic [DW-1:0] b_mem_rd_data, b_dump_data;
  logic [1:0]    b_stop_cause;

  int checks = 0;
  int errors = 0;

  cpu_run_dump_ctrl dut_a (
    .clock(clock), .reset_n(reset_n), .start(a_start), .cycle_limit(a_cycle_limit),
    .cpu_halt(a_cpu_halt), .cpu_run(a_cpu_run), .mem_rd_en(a_mem_rd_en),
    .mem_rd_addr(a_mem_rd_addr), .mem_rd_data(a_mem_rd_data), .dump_valid(a_dump_valid),
    .dump_ready(a_dump_ready), .dump_addr(a_dump_addr), .dump_data(a_dump_data),
    .dump_last(a_dump_last), .busy(a_busy), .done(a_done), .cycles_run(a_cycles_run),
    .stop_cause(a_stop_cause)
  );

  cpu_run_dump_ctrl #(.DUMP_DEPTH(4), .MEM_RD_LAT(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(b_start), .cycle_limit(b_cycle_limit),
    .cpu_halt(b_cpu_halt), .cpu_run(b_cpu_run), .mem_rd_en(b_mem_rd_en),
    .mem_rd_addr(b_mem_rd_addr), .mem_rd_data(b_mem_rd_data), .dump_valid(b_dump_valid),
    .dump_ready(b_dump_ready), .dump_addr(b_dump_addr), .dump_data(b_dump_data),
    .dump_last(b_dump_last), .busy(b_busy), .done(b_done), .cycles_run(b_cycles_run),
    .stop_cause(b_stop_cause)
  );

  // Memories return junk except in exactly the cycle the data is due.
  logic [DW-1:0] a_mem [16];
  logic [DW-1:0] b_mem [16];
  logic          a_rv;
  logic [AW-1:0] a_ra;
  logic [2:0]    b_rv;
  logic [AW-1:0] b_ra [3];
  always @(posedge clock) begin
    a_rv    <= a_mem_rd_en;
    a_ra    <= a_mem_rd_addr;
    b_rv    <= {b_rv[1:0], b_mem_rd_en};
    b_ra[0] <= b_mem_rd_addr;
    b_ra[1] <= b_ra[0];
    b_ra[2] <= b_ra[1];
  end
  assign a_mem_rd_data = a_rv    ? a_mem[a_ra]    : 16'hDEAD;
  assign b_mem_rd_data = b_rv[2] ? b_mem[b_ra[2]] : 16'hBEEF;

  int            a_run_cnt = 0;
  int            a_rd_cnt  = 0;
  logic [AW-1:0] a_hs_addr [$];
  logic [DW-1:0] a_hs_data [$];
  logic          a_hs_last [$];
  int            b_cyc = 0;
  int            b_hs_cyc  [$];
  logic [AW-1:0] b_hs_addr [$];
  logic [DW-1:0] b_hs_data [$];
  logic          b_hs_last [$];
  always @(negedge clock) begin
    b_cyc++;
    if (a_cpu_run)   a_run_cnt++;
    if (a_mem_rd_en) a_rd_cnt++;
    if (a_dump_valid && a_dump_ready) begin
      a_hs_addr.push_back(a_dump_addr);
      a_hs_data.push_back(a_dump_data);
      a_hs_last.push_back(a_dump_last);
    end
    if (b_dump_valid && b_dump_ready) begin
      b_hs_cyc.push_back(b_cyc);
      b_hs_addr.push_back(b_dump_addr);
      b_hs_data.push_back(b_dump_data);
      b_hs_last.push_back(b_dump_last);
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Reference: the run stops at the earlier of the halt cycle and the budget.
  function automatic void model_run(input int limit, input int halt_k, output int k,
                                    output logic [1:0] cause);
    int lim;
    lim = (limit == 0) ? 45 : limit;
    k = (halt_k >= 1 && halt_k <= lim) ? halt_k : lim;
    cause[1] = (halt_k == k);
    cause[0] = (lim == k);
  endfunction

  task automatic do_run_a(input logic [CW-1:0] limit, input int halt_k, input int ready_pct,
                          input bit junk, output bit first_ok, output bit timeout);
    a_cycle_limit = limit;
    a_start = 1'b1;
    step;
    a_start = 1'b0;
    a_cycle_limit = CW'($urandom);
    first_ok = (a_cpu_run === 1'b1) && (a_cycles_run === 16'd0) && (a_busy === 1'b1) && (a_done === 1'b0);
    timeout = 1'b1;
    for (int i = 1; i <= 4000; i++) begin
      if (a_done) begin
        timeout = 1'b0;
        break;
      end
      a_cpu_halt   = (i == halt_k);
      a_dump_ready = ($urandom_range(0, 99) < ready_pct);
      a_start      = junk && (i == 3);
      step;
    end
    a_cpu_halt = 1'b0;
    a_start = 1'b0;
    a_dump_ready = 1'b0;
  endtask

  task automatic test_run_and_dump(input string tag, input logic [CW-1:0] limit, input int halt_k,
                                   input int ready_pct, input bit junk);
    int k, hb, rb, db, n;
    logic [1:0] cause;
    bit to, first_ok;
    model_run(int'(limit), halt_k, k, cause);
    hb = a_hs_addr.size();
    rb = a_run_cnt;
    db = a_rd_cnt;
    do_run_a(limit, halt_k, ready_pct, junk, first_ok, to);
    checks++; if (to) begin errors++; $display("FAIL %s done_timeout got busy=%0b want done=1", tag, a_busy); end
    checks++; if (!first_ok) begin errors++; $display("FAIL %s run_start got cpu_run=%0b cycles_run=%0d want 1 and 0", tag, a_cpu_run, a_cycles_run); end
    checks++; if (a_cycles_run !== CW'(k)) begin errors++; $display("FAIL %s cycles_run got %0d want %0d", tag, a_cycles_run, k); end
    checks++; if (a_stop_cause !== cause) begin errors++; $display("FAIL %s stop_cause got %b want %b", tag, a_stop_cause, cause); end
    checks++; if (a_run_cnt - rb != k) begin errors++; $display("FAIL %s cpu_run_cycles got %0d want %0d", tag, a_run_cnt - rb, k); end
    checks++; if (a_rd_cnt - db != 16) begin errors++; $display("FAIL %s rd_strobes got %0d want 16", tag, a_rd_cnt - db); end
    checks++; if ({a_done, a_busy} !== 2'b10) begin errors++; $display("FAIL %s done_busy got %b want 10", tag, {a_done, a_busy}); end
    n = a_hs_addr.size() - hb;
    checks++; if (n != 16) begin errors++; $display("FAIL %s handshakes got %0d want 16", tag, n); end
    for (int j = 0; j < n && j < 16; j++) begin
      checks++;
      if (a_hs_addr[hb+j] !== AW'(j) || a_hs_data[hb+j] !== a_mem[j] || a_hs_last[hb+j] !== (j == 15)) begin
        errors++;
        $display("FAIL %s word%0d got addr=%0d data=%h last=%0b want addr=%0d data=%h last=%0b",
                 tag, j, a_hs_addr[hb+j], a_hs_data[hb+j], a_hs_last[hb+j], j, a_mem[j], (j == 15));
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    step; step; step;
    checks++;
    if ({a_cpu_run, a_mem_rd_en, a_mem_rd_addr, a_dump_valid, a_dump_addr, a_dump_data, a_dump_last,
         a_busy, a_done, a_cycles_run, a_stop_cause} !== 48'd0) begin
      errors++; $display("FAIL reset_a outputs got nonzero busy=%0b done=%0b want all 0", a_busy, a_done);
    end
    checks++;
    if ({b_cpu_run, b_mem_rd_en, b_mem_rd_addr, b_dump_valid, b_dump_addr, b_dump_data, b_dump_last,
         b_busy, b_done, b_cycles_run, b_stop_cause} !== 48'd0) begin
      errors++; $display("FAIL reset_b outputs got nonzero busy=%0b done=%0b want all 0", b_busy, b_done);
    end
    reset_n = 1'b1;
    step; step;
    checks++;
    if ({a_cpu_run, a_busy, a_done, a_dump_valid, a_mem_rd_en} !== 5'd0) begin
      errors++; $display("FAIL idle_after_reset got %b want 00000", {a_cpu_run, a_busy, a_done, a_dump_valid, a_mem_rd_en});
    end
  endtask

  task automatic test_default_limit;
    for (int j = 0; j < 16; j++) a_mem[j] = DW'($urandom);
    test_run_and_dump("default_limit", 16'd0, 0, 100, 1'b1);
  endtask

  task automatic test_halt;
    for (int j = 0; j < 16; j++) a_mem[j] = DW'(j * 3);
    test_run_and_dump("halt_k4", 16'd10, 4, 100, 1'b0);
  endtask

  task automatic test_both_causes;
    for (int j = 0; j < 16; j++) a_mem[j] = DW'($urandom);
    test_run_and_dump("both_causes", 16'd7, 7, 70, 1'b0);
  endtask

  task automatic test_ready_stall;
    int stall, hb;
    bit to;
    for (int j = 0; j < 16; j++) a_mem[j] = DW'($urandom);
    hb = a_hs_addr.size();
    stall = 0;
    a_cycle_limit = 16'd3;
    a_start = 1'b1;
    step;
    a_start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (a_done) begin
        to = 1'b0;
        break;
      end
      if (stall == 0 && a_dump_valid && a_dump_addr == 4'd2) stall = 1;
      if (stall >= 1 && stall <= 5) begin
        a_dump_ready = 1'b0;
        checks++;
        if ({a_dump_valid, a_dump_addr, a_dump_data, a_dump_last, a_mem_rd_en} !== {1'b1, 4'd2, a_mem[2], 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL stall%0d got valid=%0b addr=%0d data=%h last=%0b rd_en=%0b want 1 2 %h 0 0",
                   stall, a_dump_valid, a_dump_addr, a_dump_data, a_dump_last, a_mem_rd_en, a_mem[2]);
        end
        stall++;
      end else begin
        a_dump_ready = 1'b1;
      end
      step;
    end
    a_dump_ready = 1'b0;
    checks++; if (to || stall != 6) begin errors++; $display("FAIL stall_run got timeout=%0b stall_cycles=%0d want 0 and 5", to, stall - 1); end
    checks++; if (a_hs_addr.size() - hb != 16) begin errors++; $display("FAIL stall_handshakes got %0d want 16", a_hs_addr.size() - hb); end
    checks++; if (a_cycles_run !== 16'd3) begin errors++; $display("FAIL stall_cycles_run got %0d want 3", a_cycles_run); end
  endtask

  task automatic test_back_to_back;
    int hb, n;
    bit to;
    b_dump_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int j = 0; j < 4; j++) b_mem[j] = DW'($urandom);
      hb = b_hs_addr.size();
      b_cycle_limit = 16'd2;
      b_start = 1'b1;
      step;
      b_start = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 500; i++) begin
        if (b_done) begin
          to = 1'b0;
          break;
        end
        step;
      end
      checks++; if (to) begin errors++; $display("FAIL b2b%0d done_timeout got busy=%0b want done=1", rep, b_busy); end
      checks++; if ({b_cycles_run, b_stop_cause} !== {16'd2, 2'b01}) begin errors++; $display("FAIL b2b%0d run got cycles=%0d cause=%b want 2 01", rep, b_cycles_run, b_stop_cause); end
      n = b_hs_addr.size() - hb;
      checks++; if (n != 4) begin errors++; $display("FAIL b2b%0d handshakes got %0d want 4", rep, n); end
      for (int j = 0; j < n && j < 4; j++) begin
        checks++;
        if (b_hs_addr[hb+j] !== AW'(j) || b_hs_data[hb+j] !== b_mem[j] || b_hs_last[hb+j] !== (j == 3)) begin
          errors++;
          $display("FAIL b2b%0d word%0d got addr=%0d data=%h last=%0b want %0d %h %0b",
                   rep, j, b_hs_addr[hb+j], b_hs_data[hb+j], b_hs_last[hb+j], j, b_mem[j], (j == 3));
        end
        if (j > 0) begin
          checks++;
          if (b_hs_cyc[hb+j] - b_hs_cyc[hb+j-1] != 5) begin
            errors++; $display("FAIL b2b%0d spacing%0d got %0d want 5", rep, j, b_hs_cyc[hb+j] - b_hs_cyc[hb+j-1]);
          end
        end
      end
    end
    b_dump_ready = 1'b0;
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < 16; j++) a_mem[j] = DW'($urandom);
      test_run_and_dump($sformatf("random%0d", it), CW'($urandom_range(0, 20)),
                        int'($urandom_range(0, 24)), int'($urandom_range(30, 100)), 1'b1);
    end
  endtask

  task automatic test_reset_mid_dump;
    bit hit;
    for (int j = 0; j < 16; j++) a_mem[j] = DW'($urandom);
    hit = 1'b0;
    a_cycle_limit = 16'd1;
    a_start = 1'b1;
    step;
    a_start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (a_dump_valid && a_dump_addr == 4'd5) begin
        a_dump_ready = 1'b0;
        hit = 1'b1;
        break;
      end
      a_dump_ready = 1'b1;
      step;
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_reach got addr=%0d want addr 5 valid", a_dump_addr); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({a_cpu_run, a_mem_rd_en, a_mem_rd_addr, a_dump_valid, a_dump_addr, a_dump_data, a_dump_last,
         a_busy, a_done, a_cycles_run, a_stop_cause} !== 48'd0) begin
      errors++; $display("FAIL abort_outputs got valid=%0b addr=%0d busy=%0b want all 0", a_dump_valid, a_dump_addr, a_busy);
    end
    step; step;
    reset_n = 1'b1;
    a_dump_ready = 1'b1;
    step; step; step;
    checks++;
    if ({a_cpu_run, a_busy, a_done, a_dump_valid, a_mem_rd_en} !== 5'd0) begin
      errors++; $display("FAIL abort_idle got %b want 00000", {a_cpu_run, a_busy, a_done, a_dump_valid, a_mem_rd_en});
    end
    test_run_and_dump("after_abort", 16'd6, 0, 80, 1'b0);
  endtask

  initial begin
    reset_n = 1'b1;
    a_start = 1'b0; a_cycle_limit = 16'd0; a_cpu_halt = 1'b0; a_dump_ready = 1'b0;
    b_start = 1'b0; b_cycle_limit = 16'd0; b_cpu_halt = 1'b0; b_dump_ready = 1'b0;
    for (int j = 0; j < 16; j++) begin
      a_mem[j] = 16'd0;
      b_mem[j] = 16'd0;
    end
    test_reset;
    test_default_limit;
    test_halt;
    test_both_causes;
    test_ready_stall;
    test_back_to_back;
    test_random;
    test_reset_mid_dump;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
